// File: rtl/serial_word_deser.sv
// Serial-to-parallel word receiver: packs LANES-bit beats into WORD_W-bit words
// and queues them in a small valid/ready output FIFO with sticky error flags.
module serial_word_deser #(
  parameter int WORD_W     = 24,
  parameter int LANES      = 1,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_en,
  input  logic [LANES-1:0]                  i_din,
  input  logic                              i_din_valid,
  input  logic                              i_sof,
  output logic [WORD_W-1:0]                 o_dout,
  output logic                              o_dout_valid,
  input  logic                              i_dout_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_level,
  output logic                              o_overrun,
  output logic                              o_sync_err,
  input  logic                              i_clr_err
);

  localparam int BEATS = WORD_W / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_idx;
  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_din_ext;
  logic [WORD_W-1:0] w_lane_mask;
  logic [31:0]       w_lo;
  logic              w_beat;
  logic              w_last;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_push_ok;
  logic              w_ovr_set;
  logic              w_sync_set;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic              r_overrun;
  logic              r_sync_err;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A qualified sof forces this beat into slot 0 and discards any partial word.
  assign w_beat = i_en & i_din_valid;
  assign w_idx  = i_sof ? '0 : r_cnt;
  assign w_last = (w_idx == CNT_W'(BEATS - 1));

  always_comb begin
    w_lo = MSB_FIRST ? (32'(WORD_W - LANES) - 32'(w_idx) * 32'(LANES))
                     : (32'(w_idx) * 32'(LANES));
    w_din_ext   = WORD_W'(i_din);
    w_lane_mask = WORD_W'({LANES{1'b1}});
    w_word      = ((i_sof ? '0 : r_shift) & ~(w_lane_mask << w_lo)) | (w_din_ext << w_lo);
  end

  assign o_dout_valid = (r_level != '0);
  assign w_pop        = o_dout_valid & i_dout_ready;
  assign w_full       = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_push       = w_beat & w_last;
  // A pop on the same edge frees the slot, so a full FIFO can still take the word.
  assign w_push_ok    = w_push & (~w_full | w_pop);
  assign w_ovr_set    = w_push & w_full & ~w_pop;
  assign w_sync_set   = w_beat & i_sof & (r_cnt != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_beat) begin
      if (w_last) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else begin
        r_cnt   <= w_idx + 1'b1;
        r_shift <= w_word;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overrun  <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      r_overrun  <= w_ovr_set  | (r_overrun  & ~i_clr_err);
      r_sync_err <= w_sync_set | (r_sync_err & ~i_clr_err);
    end
  end

  // Head word is masked while empty so stale RAM contents never reach the port.
  assign o_dout     = o_dout_valid ? r_mem[r_rd_ptr] : '0;
  assign o_level    = r_level;
  assign o_overrun  = r_overrun;
  assign o_sync_err = r_sync_err;

endmodule
